// File: rtl/xbar_bypass_cfg_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// xbar_bypass_cfg_sequencer_pkg
// Shared definitions for the bypass-crossbar configuration sequencer:
//   - crossbar output-port indices (EAST..TREG)
//   - reserved select codes (idle / illegal)
//   - 22-bit per-context routing word layout
//   - sequencer FSM state encoding
// ----------------------------------------------------------------------------
package xbar_bypass_cfg_sequencer_pkg;

    localparam int NUM_PORTS = 6;

    localparam int EAST  = 0;
    localparam int SOUTH = 1;
    localparam int WEST  = 2;
    localparam int NORTH = 3;
    localparam int ALU_T = 4;
    localparam int TREG  = 5;

    // Code 7 parks a port (no source selected); code 6 has no meaning and is
    // flagged as a configuration error.
    localparam logic [2:0] XBAR_SEL_IDLE    = 3'b111;
    localparam logic [2:0] XBAR_SEL_ILLEGAL = 3'b110;

    // sel[i] occupies bits [3i+2:3i]; regbypass occupies [21:18].
    typedef struct packed {
        logic [3:0]      regbypass;
        logic [5:0][2:0] sel;
    } xbar_ctx_word_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/xbar_bypass_cfg_sequencer_decoder_onehot.sv
// ----------------------------------------------------------------------------
// decoder_onehot
// Turns one 3-bit crossbar select code into a 6-bit one-hot select.
//   code    : encoded source (0..5 = source index, 7 = idle, 6 = illegal)
//   onehot  : one-hot select, all-zero for idle or illegal codes
//   illegal : high when code is the reserved illegal value
// ----------------------------------------------------------------------------
module decoder_onehot
    import xbar_bypass_cfg_sequencer_pkg::*;
(
    input  logic [2:0] code,
    output logic [5:0] onehot,
    output logic       illegal
);

    always_comb begin
        onehot  = '0;
        illegal = 1'b0;
        if (code == XBAR_SEL_ILLEGAL) begin
            illegal = 1'b1;
        end else if (code != XBAR_SEL_IDLE) begin
            onehot = 6'b000001 << code;
        end
    end

endmodule

// File: rtl/xbar_bypass_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// xbar_bypass_cfg_sequencer
// Stores per-context crossbar routing words and replays them in a modulo
// schedule, driving six one-hot output selects and the regbypass vector.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   i__cfg_valid/ready  : config write handshake
//   i__cfg_addr/data    : context index and 22-bit routing word
//   i__ii, i__num_iter  : initiation interval and iteration count (on start)
//   i__start            : single-cycle start pulse
//   i__stall            : freezes the schedule (outputs, ctx, iter hold)
//   o__sel[6]           : one-hot select per port (EAST,SOUTH,WEST,NORTH,ALU_T,TREG)
//   o__regbypass        : bypass enables [0]=E [1]=W [2]=N [3]=S
//   o__ctx_id           : context currently driven
//   o__busy, o__done    : running / one-cycle completion pulse
//   o__cfg_err          : sticky config error, cleared by an accepted start
//   o__dbg_state        : current FSM state (seq_state_t encoding)
//
// Handshake: a config write transfers on a clock edge where i__cfg_valid and
// o__cfg_ready are both high. o__cfg_ready is high only in IDLE and does not
// depend on i__cfg_valid; a valid request may be held until it is accepted.
// ----------------------------------------------------------------------------
module xbar_bypass_cfg_sequencer
    import xbar_bypass_cfg_sequencer_pkg::*;
#(
    parameter int NUM_CONTEXTS   = 16,
    parameter int CTX_ADDR_WIDTH = $clog2(NUM_CONTEXTS),
    parameter int ITER_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i__cfg_valid,
    output logic                      o__cfg_ready,
    input  logic [CTX_ADDR_WIDTH-1:0] i__cfg_addr,
    input  logic [21:0]               i__cfg_data,
    input  logic [CTX_ADDR_WIDTH:0]   i__ii,
    input  logic [ITER_WIDTH-1:0]     i__num_iter,
    input  logic                      i__start,
    input  logic                      i__stall,
    output logic [5:0]                o__sel [NUM_PORTS],
    output logic [3:0]                o__regbypass,
    output logic [CTX_ADDR_WIDTH-1:0] o__ctx_id,
    output logic                      o__busy,
    output logic                      o__done,
    output logic                      o__cfg_err,
    output logic [1:0]                o__dbg_state
);

    seq_state_t                state;
    logic [CTX_ADDR_WIDTH-1:0] ctx;
    logic [ITER_WIDTH-1:0]     iter;
    logic [ITER_WIDTH-1:0]     iter_last;   // num_iter-1, avoids overflow at max
    logic [CTX_ADDR_WIDTH:0]   ii_last;     // ii-1
    logic                      last_issued; // final context of final iteration is on the outputs

    xbar_ctx_word_t            mem [NUM_CONTEXTS];
    xbar_ctx_word_t            rd_word;
    logic [5:0]                dec_sel [NUM_PORTS];
    logic [NUM_PORTS-1:0]      dec_illegal;

    logic addr_ok;
    logic wr_en;
    logic start_ok;

    assign o__cfg_ready = (state == S_IDLE);
    assign o__dbg_state = state;

    assign addr_ok  = ({1'b0, i__cfg_addr} < (CTX_ADDR_WIDTH+1)'(NUM_CONTEXTS));
    assign wr_en    = i__cfg_valid && o__cfg_ready && addr_ok;
    assign start_ok = (i__ii != '0)
                   && (i__ii <= (CTX_ADDR_WIDTH+1)'(NUM_CONTEXTS))
                   && (i__num_iter != '0);

    // ctx is held at 0 outside RUN, so this read also supplies context 0 on
    // the start edge.
    assign rd_word = mem[ctx];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        decoder_onehot u_dec (
            .code    (rd_word.sel[p]),
            .onehot  (dec_sel[p]),
            .illegal (dec_illegal[p])
        );
    end

    // Context memory: not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[i__cfg_addr] <= xbar_ctx_word_t'(i__cfg_data);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            ctx          <= '0;
            iter         <= '0;
            iter_last    <= '0;
            ii_last      <= '0;
            last_issued  <= 1'b0;
            o__regbypass <= '0;
            o__ctx_id    <= '0;
            o__busy      <= 1'b0;
            o__done      <= 1'b0;
            o__cfg_err   <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) o__sel[p] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i__cfg_valid && !addr_ok) o__cfg_err <= 1'b1;
                    if (i__start) begin
                        if (start_ok) begin
                            // Start edge issues context 0 directly.
                            state        <= S_RUN;
                            o__busy      <= 1'b1;
                            o__sel       <= dec_sel;
                            o__regbypass <= rd_word.regbypass;
                            o__ctx_id    <= '0;
                            o__cfg_err   <= |dec_illegal;
                            ii_last      <= i__ii - 1'b1;
                            iter_last    <= i__num_iter - 1'b1;
                            iter         <= '0;
                            last_issued  <= 1'b0;
                            if (i__ii == (CTX_ADDR_WIDTH+1)'(1)) begin
                                ctx <= '0;
                                if (i__num_iter == ITER_WIDTH'(1)) last_issued <= 1'b1;
                                else                               iter        <= ITER_WIDTH'(1);
                            end else begin
                                ctx <= CTX_ADDR_WIDTH'(1);
                            end
                        end else begin
                            o__cfg_err <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (!i__stall) begin
                        if (last_issued) begin
                            state        <= S_DONE;
                            o__busy      <= 1'b0;
                            o__done      <= 1'b1;
                            o__regbypass <= '0;
                            o__ctx_id    <= '0;
                            last_issued  <= 1'b0;
                            for (int p = 0; p < NUM_PORTS; p++) o__sel[p] <= '0;
                        end else begin
                            o__sel       <= dec_sel;
                            o__regbypass <= rd_word.regbypass;
                            o__ctx_id    <= ctx;
                            if (|dec_illegal) o__cfg_err <= 1'b1;
                            if ({1'b0, ctx} == ii_last) begin
                                ctx <= '0;
                                if (iter == iter_last) last_issued <= 1'b1;
                                else                   iter        <= iter + 1'b1;
                            end else begin
                                ctx <= ctx + 1'b1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    o__done <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_bypass_cfg_sequencer.sv
module tb_xbar_bypass_cfg_sequencer;
    import xbar_bypass_cfg_sequencer_pkg::*;

    localparam int NC = 16;
    localparam int AW = 4;
    localparam int IW = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          i__cfg_valid = 1'b0;
    logic          o__cfg_ready;
    logic [AW-1:0] i__cfg_addr  = '0;
    logic [21:0]   i__cfg_data  = '0;
    logic [AW:0]   i__ii        = '0;
    logic [IW-1:0] i__num_iter  = '0;
    logic          i__start     = 1'b0;
    logic          i__stall     = 1'b0;
    logic [5:0]    o__sel [6];
    logic [3:0]    o__regbypass;
    logic [AW-1:0] o__ctx_id;
    logic          o__busy;
    logic          o__done;
    logic          o__cfg_err;
    logic [1:0]    o__dbg_state;

    int checks = 0;
    int errors = 0;

    xbar_bypass_cfg_sequencer #(
        .NUM_CONTEXTS(NC), .CTX_ADDR_WIDTH(AW), .ITER_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset),
        .i__cfg_valid(i__cfg_valid), .o__cfg_ready(o__cfg_ready),
        .i__cfg_addr(i__cfg_addr), .i__cfg_data(i__cfg_data),
        .i__ii(i__ii), .i__num_iter(i__num_iter),
        .i__start(i__start), .i__stall(i__stall),
        .o__sel(o__sel), .o__regbypass(o__regbypass), .o__ctx_id(o__ctx_id),
        .o__busy(o__busy), .o__done(o__done), .o__cfg_err(o__cfg_err),
        .o__dbg_state(o__dbg_state)
    );

    // ---------------- stimulus helpers ----------------
    function automatic logic [21:0] mk_word(input int port, input logic [2:0] code,
                                            input logic [3:0] rb);
        logic [21:0] w;
        w = {rb, 18'h3FFFF};
        if (port >= 0) w[3*port +: 3] = code;
        return w;
    endfunction

    logic [21:0] w_r0, w_r1, w_idle, w_ill, w_new;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ctx(input logic [AW-1:0] a, input logic [21:0] d);
        i__cfg_valid = 1'b1;
        i__cfg_addr  = a;
        i__cfg_data  = d;
        tick();
        i__cfg_valid = 1'b0;
    endtask

    // Returns just after the start edge; the next negedge is run cycle 0.
    task automatic start_run(input logic [AW:0] ii, input logic [IW-1:0] n);
        i__ii       = ii;
        i__num_iter = n;
        i__start    = 1'b1;
        tick();
        i__start    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++; if (o__cfg_ready !== 1'b1) begin errors++; $display("FAIL reset0 cfg_ready: got %b exp 1", o__cfg_ready); end
        checks++; if (o__busy !== 1'b0 || o__done !== 1'b0 || o__cfg_err !== 1'b0) begin errors++; $display("FAIL reset0 flags: busy %b done %b err %b exp 000", o__busy, o__done, o__cfg_err); end
        checks++; if (o__regbypass !== 4'h0 || o__ctx_id !== '0) begin errors++; $display("FAIL reset0 rb/ctx: got %h/%h exp 0/0", o__regbypass, o__ctx_id); end
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        write_ctx(0, w_r0);
        start_run(1, 20);
        tick();
        #3;
        checks++; if (o__busy !== 1'b1) begin errors++; $display("FAIL reset_mid pre busy: got %b exp 1", o__busy); end
        reset = 1'b0;
        #1;
        checks++; if (o__busy !== 1'b0 || o__done !== 1'b0) begin errors++; $display("FAIL reset_mid busy/done: got %b/%b exp 0/0", o__busy, o__done); end
        checks++; if (o__cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_mid cfg_ready: got %b exp 1", o__cfg_ready); end
        for (int p = 0; p < 6; p++) begin
            checks++; if (o__sel[p] !== 6'b0) begin errors++; $display("FAIL reset_mid sel%0d: got %b exp 000000", p, o__sel[p]); end
        end
        checks++; if (o__regbypass !== 4'h0 || o__dbg_state !== 2'd0) begin errors++; $display("FAIL reset_mid rb/state: got %h/%0d exp 0/0", o__regbypass, o__dbg_state); end
        #2 reset = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (o__dbg_state !== 2'd0 || o__busy !== 1'b0 || o__done !== 1'b0) begin errors++; $display("FAIL reset_post state/busy/done: got %0d/%b/%b exp 0/0/0", o__dbg_state, o__busy, o__done); end
    endtask

    task automatic test_replay_wrap();
        write_ctx(0, w_r0);
        write_ctx(1, w_r1);
        start_run(2, 3);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (o__busy !== 1'b1 || o__done !== 1'b0 || o__cfg_ready !== 1'b0) begin errors++; $display("FAIL replay c%0d busy/done/ready: got %b/%b/%b exp 1/0/0", c, o__busy, o__done, o__cfg_ready); end
            checks++; if (o__ctx_id !== AW'(c % 2)) begin errors++; $display("FAIL replay c%0d ctx_id: got %0d exp %0d", c, o__ctx_id, c % 2); end
            checks++; if (o__sel[EAST] !== ((c % 2) == 0 ? 6'b010000 : 6'b000000)) begin errors++; $display("FAIL replay c%0d sel_east: got %b", c, o__sel[EAST]); end
            checks++; if (o__sel[ALU_T] !== ((c % 2) == 1 ? 6'b000001 : 6'b000000)) begin errors++; $display("FAIL replay c%0d sel_alu: got %b", c, o__sel[ALU_T]); end
            checks++; if (o__regbypass !== ((c % 2) == 0 ? 4'b0001 : 4'b1000)) begin errors++; $display("FAIL replay c%0d regbypass: got %b", c, o__regbypass); end
        end
        @(negedge clk);
        checks++; if (o__done !== 1'b1 || o__busy !== 1'b0) begin errors++; $display("FAIL replay done: done %b busy %b exp 1/0", o__done, o__busy); end
        checks++; if (o__sel[EAST] !== 6'b0 || o__sel[ALU_T] !== 6'b0 || o__regbypass !== 4'h0) begin errors++; $display("FAIL replay done outputs: e %b a %b rb %b exp 0", o__sel[EAST], o__sel[ALU_T], o__regbypass); end
        @(negedge clk);
        checks++; if (o__done !== 1'b0 || o__dbg_state !== 2'd0 || o__cfg_ready !== 1'b1) begin errors++; $display("FAIL replay idle: done %b state %0d ready %b exp 0/0/1", o__done, o__dbg_state, o__cfg_ready); end
    endtask

    task automatic test_stall();
        logic [AW-1:0] ctx_tab [9];
        ctx_tab = '{0, 1, 1, 1, 1, 0, 1, 0, 1};
        start_run(2, 3);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++; if (o__busy !== 1'b1 || o__ctx_id !== ctx_tab[c]) begin errors++; $display("FAIL stall c%0d busy/ctx: got %b/%0d exp 1/%0d", c, o__busy, o__ctx_id, ctx_tab[c]); end
            checks++; if (o__sel[EAST] !== (ctx_tab[c] == 0 ? 6'b010000 : 6'b000000)) begin errors++; $display("FAIL stall c%0d sel_east: got %b", c, o__sel[EAST]); end
            i__stall = (c >= 1 && c <= 3);
        end
        i__stall = 1'b0;
        @(negedge clk);
        checks++; if (o__done !== 1'b1 || o__busy !== 1'b0) begin errors++; $display("FAIL stall done: done %b busy %b exp 1/0", o__done, o__busy); end
        @(negedge clk);
        checks++; if (o__dbg_state !== 2'd0) begin errors++; $display("FAIL stall idle state: got %0d exp 0", o__dbg_state); end
    endtask

    task automatic test_illegal_idle();
        write_ctx(0, w_ill);
        write_ctx(1, w_idle);
        start_run(2, 1);
        @(negedge clk);
        checks++; if (o__sel[WEST] !== 6'b0 || o__cfg_err !== 1'b1 || o__busy !== 1'b1) begin errors++; $display("FAIL illegal c0 west/err/busy: got %b/%b/%b exp 0/1/1", o__sel[WEST], o__cfg_err, o__busy); end
        checks++; if (o__sel[EAST] !== 6'b0 || o__sel[TREG] !== 6'b0) begin errors++; $display("FAIL illegal c0 idle ports: e %b t %b exp 0", o__sel[EAST], o__sel[TREG]); end
        @(negedge clk);
        checks++; if (o__ctx_id !== AW'(1) || o__cfg_err !== 1'b1 || o__sel[NORTH] !== 6'b0) begin errors++; $display("FAIL illegal c1 ctx/err/north: got %0d/%b/%b exp 1/1/0", o__ctx_id, o__cfg_err, o__sel[NORTH]); end
        @(negedge clk);
        checks++; if (o__done !== 1'b1 || o__cfg_err !== 1'b1) begin errors++; $display("FAIL illegal done/err: got %b/%b exp 1/1", o__done, o__cfg_err); end
        @(negedge clk);
        checks++; if (o__cfg_err !== 1'b1 || o__dbg_state !== 2'd0) begin errors++; $display("FAIL illegal sticky err/state: got %b/%0d exp 1/0", o__cfg_err, o__dbg_state); end
        write_ctx(0, w_idle);
        start_run(1, 2);
        @(negedge clk);
        checks++; if (o__cfg_err !== 1'b0 || o__busy !== 1'b1 || o__sel[WEST] !== 6'b0) begin errors++; $display("FAIL idlecode c0 err/busy/west: got %b/%b/%b exp 0/1/0", o__cfg_err, o__busy, o__sel[WEST]); end
        @(negedge clk);
        checks++; if (o__cfg_err !== 1'b0 || o__busy !== 1'b1 || o__ctx_id !== '0) begin errors++; $display("FAIL idlecode c1 err/busy/ctx: got %b/%b/%0d exp 0/1/0", o__cfg_err, o__busy, o__ctx_id); end
        @(negedge clk);
        checks++; if (o__done !== 1'b1 || o__cfg_err !== 1'b0) begin errors++; $display("FAIL idlecode done/err: got %b/%b exp 1/0", o__done, o__cfg_err); end
        @(negedge clk);
    endtask

    task automatic test_bad_start();
        // ctx0 holds the all-idle word here
        start_run(0, 1);
        @(negedge clk);
        checks++; if (o__busy !== 1'b0 || o__cfg_err !== 1'b1 || o__dbg_state !== 2'd0) begin errors++; $display("FAIL bad_ii0 busy/err/state: got %b/%b/%0d exp 0/1/0", o__busy, o__cfg_err, o__dbg_state); end
        start_run(1, 1);
        @(negedge clk);
        checks++; if (o__busy !== 1'b1 || o__cfg_err !== 1'b0) begin errors++; $display("FAIL good_after_ii0 busy/err: got %b/%b exp 1/0", o__busy, o__cfg_err); end
        @(negedge clk);
        checks++; if (o__done !== 1'b1) begin errors++; $display("FAIL good_after_ii0 done: got %b exp 1", o__done); end
        @(negedge clk);
        start_run(17, 1);
        @(negedge clk);
        checks++; if (o__busy !== 1'b0 || o__cfg_err !== 1'b1 || o__dbg_state !== 2'd0) begin errors++; $display("FAIL bad_ii17 busy/err/state: got %b/%b/%0d exp 0/1/0", o__busy, o__cfg_err, o__dbg_state); end
        start_run(16, 1);
        @(negedge clk);
        checks++; if (o__busy !== 1'b1 || o__cfg_err !== 1'b0) begin errors++; $display("FAIL good_ii16 busy/err: got %b/%b exp 1/0", o__busy, o__cfg_err); end
        repeat (16) @(negedge clk);
        checks++; if (o__done !== 1'b1) begin errors++; $display("FAIL good_ii16 done after 16: got %b exp 1", o__done); end
        @(negedge clk);
        start_run(2, 0);
        @(negedge clk);
        checks++; if (o__busy !== 1'b0 || o__cfg_err !== 1'b1) begin errors++; $display("FAIL bad_niter0 busy/err: got %b/%b exp 0/1", o__busy, o__cfg_err); end
    endtask

    task automatic test_write_blocked();
        write_ctx(0, w_r0);
        write_ctx(1, w_r1);
        start_run(2, 2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (o__cfg_ready !== 1'b0 || o__ctx_id !== AW'(c % 2)) begin errors++; $display("FAIL blocked c%0d ready/ctx: got %b/%0d exp 0/%0d", c, o__cfg_ready, o__ctx_id, c % 2); end
            i__cfg_valid = (c < 3);
            i__cfg_addr  = AW'(c % 2);
            i__cfg_data  = w_new;
        end
        i__cfg_valid = 1'b0;
        @(negedge clk);
        checks++; if (o__done !== 1'b1) begin errors++; $display("FAIL blocked done: got %b exp 1", o__done); end
        @(negedge clk);
        start_run(2, 1);
        @(negedge clk);
        checks++; if (o__sel[EAST] !== 6'b010000 || o__regbypass !== 4'b0001) begin errors++; $display("FAIL blocked rerun c0 east/rb: got %b/%b exp 010000/0001", o__sel[EAST], o__regbypass); end
        @(negedge clk);
        checks++; if (o__sel[ALU_T] !== 6'b000001 || o__sel[EAST] !== 6'b0 || o__regbypass !== 4'b1000) begin errors++; $display("FAIL blocked rerun c1 alu/east/rb: got %b/%b/%b", o__sel[ALU_T], o__sel[EAST], o__regbypass); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        write_ctx(1, w_idle);
        start_run(1, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (o__busy !== 1'b1 || o__ctx_id !== '0 || o__sel[EAST] !== 6'b010000) begin errors++; $display("FAIL ii1 c%0d busy/ctx/east: got %b/%0d/%b exp 1/0/010000", c, o__busy, o__ctx_id, o__sel[EAST]); end
        end
        @(negedge clk);
        checks++; if (o__done !== 1'b1 || o__busy !== 1'b0) begin errors++; $display("FAIL ii1 done/busy: got %b/%b exp 1/0", o__done, o__busy); end
        @(negedge clk);
        start_run(2, 1);
        @(negedge clk);
        checks++; if (o__sel[EAST] !== 6'b010000 || o__ctx_id !== '0) begin errors++; $display("FAIL b2b c0 east/ctx: got %b/%0d exp 010000/0", o__sel[EAST], o__ctx_id); end
        @(negedge clk);
        checks++; if (o__sel[EAST] !== 6'b0 || o__sel[ALU_T] !== 6'b0 || o__regbypass !== 4'h0 || o__ctx_id !== AW'(1)) begin errors++; $display("FAIL b2b c1 east/alu/rb/ctx: got %b/%b/%b/%0d", o__sel[EAST], o__sel[ALU_T], o__regbypass, o__ctx_id); end
        @(negedge clk);
        checks++; if (o__done !== 1'b1) begin errors++; $display("FAIL b2b done: got %b exp 1", o__done); end
        @(negedge clk);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        w_r0   = mk_word(EAST,  3'd4, 4'b0001);
        w_r1   = mk_word(ALU_T, 3'd0, 4'b1000);
        w_idle = mk_word(-1,    3'd0, 4'b0000);
        w_ill  = mk_word(WEST,  3'd6, 4'b0000);
        w_new  = mk_word(EAST,  3'd5, 4'b1111);

        test_reset();
        test_replay_wrap();
        test_stall();
        test_illegal_idle();
        test_bad_start();
        test_write_blocked();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
